dat_crc_rx: RTL and testbench

DAT_CRC_RX -- requirements
Module: dat_crc_rx

---
 rtl/dat_crc_rx.sv | 187 ++++++++++++++++++
 tb/tb_dat_crc_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dat_crc_rx.sv
// dat_crc_rx: receives one block from a serial DAT line.
// Waits for a start bit, takes BLOCK_BYTES data bytes MSB first while
// running a CRC16 (x^16+x^12+x^5+1, init 0) over them, then takes the
// 16-bit CRC and the end bit from the line and reports the result.
//
// Ports:
//   iclk        clock, all logic on its rising edge
//   irst        synchronous active-high reset
//   istart      arms reception of one block (honoured only in IDLE)
//   ien         bit strobe; idat is sampled only when ien=1
//   idat        serial DAT line, MSB first
//   obyte       last completed data byte
//   obyte_valid one-cycle pulse, obyte valid
//   obusy       high in every state except IDLE
//   odone       one-cycle pulse at block completion
//   ocrc_err    received CRC differed from computed CRC
//   oend_err    end bit sampled as 0
//   otimeout    no start bit within TIMEOUT strobes
module dat_crc_rx #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       istart,
    input  logic       ien,
    input  logic       idat,
    output logic [7:0] obyte,
    output logic       obyte_valid,
    output logic       obusy,
    output logic       odone,
    output logic       ocrc_err,
    output logic       oend_err,
    output logic       otimeout
);

    localparam int unsigned     NBITS    = BLOCK_BYTES * 8;
    localparam int unsigned     CW       = $clog2(NBITS) + 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(NBITS - 1);
    localparam logic [15:0]     POLY     = 16'h1021;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [6:0]    byte_sr;
    logic [15:0]   crc;
    logic [15:0]   crc_nxt;
    logic [15:0]   rx_crc;
    logic [15:0]   wait_cnt;
    logic [CW-1:0] bit_cnt;
    logic [3:0]    crc_cnt;
    logic          fb;

    assign fb      = idat ^ crc[15];
    assign crc_nxt = {crc[14:0], 1'b0} ^ ({16{fb}} & POLY);

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        obusy     = (state != IDLE);
        odone     = (state == DONE);
        case (state)
            IDLE: begin
                if (istart) begin
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (ien) begin
                    if (!idat) begin
                        state_nxt = DATA;
                    end else if (wait_cnt == TIMEOUT - 16'd1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DATA: begin
                if (ien && bit_cnt == LAST_BIT) begin
                    state_nxt = CRC;
                end
            end
            CRC: begin
                if (ien && crc_cnt == 4'd15) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (ien) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            byte_sr     <= '0;
            crc         <= '0;
            rx_crc      <= '0;
            wait_cnt    <= '0;
            bit_cnt     <= '0;
            crc_cnt     <= '0;
            obyte       <= '0;
            obyte_valid <= 1'b0;
            ocrc_err    <= 1'b0;
            oend_err    <= 1'b0;
            otimeout    <= 1'b0;
        end else begin
            obyte_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (istart) begin
                        byte_sr  <= '0;
                        crc      <= '0;
                        rx_crc   <= '0;
                        wait_cnt <= '0;
                        bit_cnt  <= '0;
                        crc_cnt  <= '0;
                        ocrc_err <= 1'b0;
                        oend_err <= 1'b0;
                        otimeout <= 1'b0;
                    end
                end
                WAIT_START: begin
                    // The start bit itself never enters the CRC.
                    if (ien && idat) begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == TIMEOUT - 16'd1) begin
                            otimeout <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (ien) begin
                        byte_sr <= {byte_sr[5:0], idat};
                        crc     <= crc_nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt[2:0] == 3'd7) begin
                            obyte       <= {byte_sr, idat};
                            obyte_valid <= 1'b1;
                        end
                    end
                end
                CRC: begin
                    // Computed CRC stays frozen while the received one shifts in.
                    if (ien) begin
                        rx_crc  <= {rx_crc[14:0], idat};
                        crc_cnt <= crc_cnt + 4'd1;
                    end
                end
                END: begin
                    // CRC compare is registered on the edge entering DONE so
                    // both error flags are already valid while odone is high.
                    if (ien) begin
                        oend_err <= ~idat;
                        ocrc_err <= (rx_crc != crc);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_crc_rx.sv
// tb_dat_crc_rx: randomized self-checking bench for dat_crc_rx.
// Blocks are built in a byte array; the expected CRC comes from a
// byte-wise CRC16 reference, expected bytes from the array itself.
module tb_dat_crc_rx;

    logic       iclk = 1'b0;
    logic       irst;
    logic       istart;
    logic       ien;
    logic       idat;
    logic [7:0] obyte;
    logic       obyte_valid;
    logic       obusy;
    logic       odone;
    logic       ocrc_err;
    logic       oend_err;
    logic       otimeout;

    int n_checks = 0;
    int n_err    = 0;
    bit rand_ien = 1'b0;

    logic [7:0] blk [512];
    logic [7:0] got_q [$];

    always #5 iclk = ~iclk;

    dat_crc_rx #(
        .BLOCK_BYTES(512),
        .TIMEOUT    (16'd16)
    ) dut (
        .iclk       (iclk),
        .irst       (irst),
        .istart     (istart),
        .ien        (ien),
        .idat       (idat),
        .obyte      (obyte),
        .obyte_valid(obyte_valid),
        .obusy      (obusy),
        .odone      (odone),
        .ocrc_err   (ocrc_err),
        .oend_err   (oend_err),
        .otimeout   (otimeout)
    );

    // Every obyte_valid pulse is captured, sampled away from the active edge.
    always @(negedge iclk) begin
        if (obyte_valid === 1'b1) begin
            got_q.push_back(obyte);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte-at-a-time CRC16-CCITT (non-reflected, init 0) over the block.
    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            c = c ^ {blk[i], 8'h00};
            for (int k = 0; k < 8; k++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic cycle(input logic e, input logic d, input logic st);
        @(posedge iclk);
        #1;
        ien    = e;
        idat   = d;
        istart = st;
    endtask

    task automatic strobe(input logic b, input logic st);
        int gaps;
        gaps = rand_ien ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i < gaps; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        cycle(1'b1, b, st);
    endtask

    task automatic run_block(input string tag, input logic [15:0] crc_tx, input logic end_bit,
                             input int lead, input bit mid_start,
                             input logic exp_crc_err, input logic exp_end_err);
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge iclk);
        check({tag, "/armed_busy"}, obusy, 1);
        check({tag, "/armed_flags"}, {ocrc_err, oend_err, otimeout}, 0);
        for (int i = 0; i < lead; i++) begin
            strobe(1'b1, 1'b0);
        end
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 512; i++) begin
            for (int k = 7; k >= 0; k--) begin
                strobe(blk[i][k], 1'(mid_start && i == 200 && k == 3));
            end
        end
        for (int k = 15; k >= 0; k--) begin
            strobe(crc_tx[k], 1'b0);
        end
        strobe(end_bit, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge iclk);
        check({tag, "/odone"}, odone, 1);
        check({tag, "/busy_in_done"}, obusy, 1);
        check({tag, "/crc_err"}, ocrc_err, exp_crc_err);
        check({tag, "/end_err"}, oend_err, exp_end_err);
        check({tag, "/timeout"}, otimeout, 0);
        check({tag, "/nbytes"}, got_q.size(), 512);
        for (int i = 0; i < 512 && i < got_q.size(); i++) begin
            check($sformatf("%s/byte%0d", tag, i), got_q[i], blk[i]);
        end
        @(negedge iclk);
        check({tag, "/odone_pulse"}, odone, 0);
        check({tag, "/idle"}, obusy, 0);
        check({tag, "/flags_hold"}, {ocrc_err, oend_err}, {exp_crc_err, exp_end_err});
    endtask

    initial begin
        irst   = 1'b1;
        istart = 1'b0;
        ien    = 1'b0;
        idat   = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        irst = 1'b0;
        @(negedge iclk);
        check("rst/obyte", obyte, 0);
        check("rst/outs", {obyte_valid, obusy, odone, ocrc_err, oend_err, otimeout}, 0);

        // All-ones block with its correct CRC.
        for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
        run_block("ff_ok", 16'h7FA1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        // Same block, CRC off by one bit.
        run_block("ff_badcrc", 16'h7FA0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        // All-zeros block, bad end bit.
        for (int i = 0; i < 512; i++) blk[i] = 8'h00;
        run_block("zero_badend", 16'h0000, 1'b0, 5, 1'b0, 1'b0, 1'b1);

        // Start bit never arrives.
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge iclk);
        check("to/early_done", odone, 0);
        check("to/early_flag", otimeout, 0);
        check("to/early_busy", obusy, 1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge iclk);
        check("to/odone", odone, 1);
        check("to/flag", otimeout, 1);
        check("to/crc_err", ocrc_err, 0);
        @(negedge iclk);
        check("to/idle", obusy, 0);
        check("to/flag_hold", otimeout, 1);
        check("to/no_bytes", got_q.size(), 0);

        // Reset mid-block, then a fresh random block.
        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
        blk[0] = 8'hA5;
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1);
        strobe(1'b0, 1'b0);
        for (int b = 0; b < 100; b++) strobe(blk[b / 8][7 - (b % 8)], 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        irst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        irst = 1'b0;
        @(negedge iclk);
        check("mrst/nbytes_before", got_q.size(), 12);
        check("mrst/obyte", obyte, 0);
        check("mrst/outs", {obyte_valid, obusy, odone, ocrc_err, oend_err, otimeout}, 0);
        run_block("after_rst", crc_model(), 1'b1, 2, 1'b0, 1'b0, 1'b0);

        // Randomly gapped strobes plus an ignored istart mid-block.
        rand_ien = 1'b1;
        for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
        run_block("ff_gapped", 16'h7FA1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
        run_block("rnd_bad", crc_model() ^ 16'h8000, 1'b0, 1, 1'b1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
